// File: rtl/if_neuron_pkg.sv
// Shared types, constants and arithmetic helpers for the integrate-and-fire array.
package if_neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    EMIT  = 2'd2
  } fsm_t;

  localparam logic RST_ZERO = 1'b0;  // spike resets membrane to zero
  localparam logic RST_SUB  = 1'b1;  // spike subtracts the threshold

  localparam int DEF_NUM_NEURONS = 16;
  localparam int DEF_STATE_W     = 12;
  localparam int DEF_WEIGHT_W    = 4;
  localparam int DEF_CNT_W       = 3;

  // Add two sign-extended operands and clamp to a w-bit two's complement range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [31:0] s, hi, lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/if_neuron_core.sv
// Combinational single-neuron update shared by the event and sweep paths.
// sweep=0: saturating integrate of weight. sweep=1: threshold check, reset on
// spike, optional leak toward zero when IF_NEURON_LEAK_EN is defined.
module if_neuron_core
  import if_neuron_pkg::*;
#(
  parameter int STATE_W  = DEF_STATE_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                sweep,
  input  logic [STATE_W-1:0]  state_in,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic [STATE_W-1:0]  thr,
  input  logic                rst_mode,
`ifdef IF_NEURON_LEAK_EN
  input  logic [STATE_W-2:0]  leak,
`endif
  output logic [STATE_W-1:0]  state_out,
  output logic                fire
);

  logic signed [31:0] a, w, t;
`ifdef IF_NEURON_LEAK_EN
  logic signed [31:0] lk;
`endif

  // Widen operands to 32-bit signed so every compare/add is overflow free.
  always_comb begin
    a = {{(32-STATE_W){state_in[STATE_W-1]}}, state_in};
    w = {{(32-WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
    t = {{(32-STATE_W){1'b0}}, thr};
`ifdef IF_NEURON_LEAK_EN
    lk = {{(33-STATE_W){1'b0}}, leak};
`endif
    fire      = sweep && (a >= t);
    state_out = state_in;
    if (!sweep) begin
      state_out = STATE_W'(sat_add(a, w, STATE_W));
    end else if (fire) begin
      // state >= thr > 0, so the subtraction cannot underflow
      state_out = (rst_mode == RST_SUB) ? STATE_W'(a - t) : '0;
    end
`ifdef IF_NEURON_LEAK_EN
    else begin
      if (a > 0)      state_out = (a > lk)     ? STATE_W'(a - lk) : '0;
      else if (a < 0) state_out = (a + lk < 0) ? STATE_W'(a + lk) : '0;
      else            state_out = '0;
    end
`endif
  end

endmodule

// File: rtl/if_neuron_array.sv
// Time-multiplexed integrate-and-fire array: events integrate into one neuron
// per handshake; a tick sweeps all neurons, firing and streaming spike indices.
// Optional leak during sweeps is enabled by defining IF_NEURON_LEAK_EN.
module if_neuron_array
  import if_neuron_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int STATE_W     = DEF_STATE_W,
  parameter int WEIGHT_W    = DEF_WEIGHT_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int N_W         = $clog2(NUM_NEURONS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [STATE_W-1:0]  param_thr,
  input  logic                param_rst_mode,
`ifdef IF_NEURON_LEAK_EN
  input  logic [STATE_W-2:0]  param_leak,
`endif
  input  logic                evt_valid,
  output logic                evt_ready,
  input  logic [N_W-1:0]      evt_neur,
  input  logic [WEIGHT_W-1:0] evt_weight,
  input  logic                tick_valid,
  output logic                tick_ready,
  output logic                spk_valid,
  input  logic                spk_ready,
  output logic [N_W-1:0]      spk_neur,
  output logic                sweep_done,
  input  logic [N_W-1:0]      rd_neur,
  output logic [STATE_W-1:0]  rd_state,
  output logic [CNT_W-1:0]    rd_pre_cnt,
  output logic [CNT_W-1:0]    rd_post_cnt,
  input  logic                cnt_clr
);

  localparam logic [N_W-1:0] LAST = N_W'(NUM_NEURONS - 1);

  fsm_t fsm, fsm_nxt;
  logic [N_W-1:0] idx, idx_nxt, cur_idx;

  logic [NUM_NEURONS-1:0][STATE_W-1:0] st_q, st_d;
  logic [NUM_NEURONS-1:0][CNT_W-1:0]   pre_q, pre_d, post_q, post_d;

  logic [STATE_W-1:0] cur_state, core_state, rd_state_d;
  logic [CNT_W-1:0]   rd_pre_d, rd_post_d;
  logic fire, wr_en, pre_inc, post_inc, spk_set, spk_clr, done_nxt;

  assign evt_ready  = (fsm == IDLE);
  assign tick_ready = (fsm == IDLE) && !evt_valid;
  // Event path addresses by evt_neur, sweep path by the running index.
  assign cur_idx    = (fsm == IDLE) ? evt_neur : idx;

  // Operand mux: fetch the addressed neuron's membrane state.
  always_comb begin
    cur_state = '0;
    for (int i = 0; i < NUM_NEURONS; i++)
      if (N_W'(i) == cur_idx) cur_state = st_q[i];
  end

  if_neuron_core #(.STATE_W(STATE_W), .WEIGHT_W(WEIGHT_W)) u_core (
    .sweep     (fsm == SWEEP),
    .state_in  (cur_state),
    .weight    (evt_weight),
    .thr       (param_thr),
    .rst_mode  (param_rst_mode),
`ifdef IF_NEURON_LEAK_EN
    .leak      (param_leak),
`endif
    .state_out (core_state),
    .fire      (fire)
  );

  // Next-state and control decode for the sweep FSM.
  always_comb begin
    fsm_nxt  = fsm;
    idx_nxt  = idx;
    wr_en    = 1'b0;
    pre_inc  = 1'b0;
    post_inc = 1'b0;
    spk_set  = 1'b0;
    spk_clr  = 1'b0;
    done_nxt = 1'b0;
    case (fsm)
      IDLE: begin
        if (evt_valid) begin
          wr_en   = 1'b1;
          pre_inc = 1'b1;
        end else if (tick_valid) begin
          idx_nxt = '0;
          fsm_nxt = SWEEP;
        end
      end
      SWEEP: begin
        wr_en = 1'b1;
        if (fire) begin
          post_inc = 1'b1;
          spk_set  = 1'b1;
          fsm_nxt  = EMIT;
        end else if (idx == LAST) begin
          done_nxt = 1'b1;
          fsm_nxt  = IDLE;
        end else begin
          idx_nxt = idx + N_W'(1);
        end
      end
      EMIT: begin
        if (spk_ready) begin
          spk_clr = 1'b1;
          if (idx == LAST) begin
            done_nxt = 1'b1;
            fsm_nxt  = IDLE;
          end else begin
            idx_nxt = idx + N_W'(1);
            fsm_nxt = SWEEP;
          end
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Next values of the neuron arrays; cnt_clr beats any increment.
  always_comb begin
    st_d       = st_q;
    pre_d      = pre_q;
    post_d     = post_q;
    rd_state_d = '0;
    rd_pre_d   = '0;
    rd_post_d  = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (wr_en && N_W'(i) == cur_idx) st_d[i] = core_state;
      if (cnt_clr) begin
        pre_d[i]  = '0;
        post_d[i] = '0;
      end else if (N_W'(i) == cur_idx) begin
        if (pre_inc && pre_q[i] != '1)   pre_d[i]  = pre_q[i] + CNT_W'(1);
        if (post_inc && post_q[i] != '1) post_d[i] = post_q[i] + CNT_W'(1);
      end
    end
    // Debug read taps the next values so a write is visible with one-cycle latency.
    for (int i = 0; i < NUM_NEURONS; i++)
      if (N_W'(i) == rd_neur) begin
        rd_state_d = st_d[i];
        rd_pre_d   = pre_d[i];
        rd_post_d  = post_d[i];
      end
  end

  // FSM state and sweep index registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm <= IDLE;
      idx <= '0;
    end else begin
      fsm <= fsm_nxt;
      idx <= idx_nxt;
    end
  end

  // Neuron storage, spike output and debug read registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q        <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      rd_state    <= '0;
      rd_pre_cnt  <= '0;
      rd_post_cnt <= '0;
      spk_valid   <= 1'b0;
      spk_neur    <= '0;
      sweep_done  <= 1'b0;
    end else begin
      st_q        <= st_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      rd_state    <= rd_state_d;
      rd_pre_cnt  <= rd_pre_d;
      rd_post_cnt <= rd_post_d;
      sweep_done  <= done_nxt;
      if (spk_set) begin
        spk_valid <= 1'b1;
        spk_neur  <= idx;
      end else if (spk_clr) begin
        spk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_neuron_array.sv
// Scoreboard bench for if_neuron_array: a reference model predicts spikes at
// tick time and pushes them to a queue, popped on each spike handshake.
module tb_if_neuron_array;

  localparam int NN = 16;
  localparam int SW = 12;
  localparam int WW = 4;
  localparam int CW = 3;
  localparam int NW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [SW-1:0] param_thr;
  logic          param_rst_mode;
  logic [SW-2:0] param_leak;
  logic          evt_valid, evt_ready, tick_valid, tick_ready;
  logic [NW-1:0] evt_neur, spk_neur, rd_neur;
  logic [WW-1:0] evt_weight;
  logic          spk_valid, spk_ready, sweep_done, cnt_clr;
  logic [SW-1:0] rd_state;
  logic [CW-1:0] rd_pre_cnt, rd_post_cnt;

  always #5 CLK = ~CLK;

  if_neuron_array #(.NUM_NEURONS(NN), .STATE_W(SW), .WEIGHT_W(WW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .param_thr(param_thr), .param_rst_mode(param_rst_mode),
`ifdef IF_NEURON_LEAK_EN
    .param_leak(param_leak),
`endif
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_neur(evt_neur),
    .evt_weight(evt_weight), .tick_valid(tick_valid), .tick_ready(tick_ready),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_neur(spk_neur),
    .sweep_done(sweep_done), .rd_neur(rd_neur), .rd_state(rd_state),
    .rd_pre_cnt(rd_pre_cnt), .rd_post_cnt(rd_post_cnt), .cnt_clr(cnt_clr)
  );

  int n_chk = 0;
  int n_fail = 0;
  int m_state[NN];
  int m_pre[NN];
  int m_post[NN];
  int exp_q[$];

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int sat(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NN; i++) begin
      m_state[i] = 0;
      m_pre[i]   = 0;
      m_post[i]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1; evt_valid = 1'b0; tick_valid = 1'b0; cnt_clr = 1'b0; spk_ready = 1'b0;
    step();
    step();
    RST = 1'b0;
    model_clear();
  endtask

  task automatic send_evts(input int n, input int w, input int count);
    evt_neur   = NW'(n);
    evt_weight = WW'(w);
    evt_valid  = 1'b1;
    repeat (count) begin
      step();
      m_state[n] = sat(m_state[n] + w);
      if (m_pre[n] < 7) m_pre[n]++;
    end
    evt_valid = 1'b0;
  endtask

  task automatic read_chk(input int n, input string tag);
    rd_neur = NW'(n);
    step();
    chk({tag, "_st"},   $signed(rd_state), m_state[n]);
    chk({tag, "_pre"},  rd_pre_cnt,        m_pre[n]);
    chk({tag, "_post"}, rd_post_cnt,       m_post[n]);
  endtask

  // Predict the spikes of one sweep and apply the reset rule to the model.
  task automatic model_tick();
    int thr;
    thr = int'(param_thr);
    for (int i = 0; i < NN; i++)
      if (m_state[i] >= thr) begin
        exp_q.push_back(i);
        if (m_post[i] < 7) m_post[i]++;
        m_state[i] = param_rst_mode ? m_state[i] - thr : 0;
      end
  endtask

  // Drain one sweep: hold spk_ready low 'stall' cycles per spike, pop on handshake.
  task automatic wait_sweep(input int stall);
    int cyc, wait_n, exp_lat;
    bit done;
    cyc = 0; wait_n = 0; done = 1'b0;
    exp_lat = NN + exp_q.size() * (1 + stall);
    while (!done && cyc < 300) begin
      if (spk_valid) begin
        if (exp_q.size() == 0) begin
          chk("spk_extra", spk_neur, -1);
          spk_ready = 1'b1;
        end else if (wait_n < stall) begin
          spk_ready = 1'b0;
          chk("spk_hold", spk_neur, exp_q[0]);
          wait_n++;
        end else begin
          spk_ready = 1'b1;
          chk("spk_neur", spk_neur, exp_q.pop_front());
          wait_n = 0;
        end
      end else begin
        spk_ready = 1'b0;
      end
      step();
      cyc++;
      if (sweep_done) done = 1'b1;
      else begin
        chk("evt_rdy_sweep", evt_ready, 0);
        chk("tick_rdy_sweep", tick_ready, 0);
      end
    end
    spk_ready = 1'b0;
    chk("sweep_lat", cyc, exp_lat);
    chk("spk_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic tick(input int stall);
    model_tick();
    tick_valid = 1'b1;
    step();
    tick_valid = 1'b0;
    wait_sweep(stall);
  endtask

  initial begin
    int seen;
    param_thr = 12'd100; param_rst_mode = 1'b0; param_leak = '0;
    rd_neur = '0; evt_neur = '0; evt_weight = '0;
    do_reset();
    chk("rst_rd_st", rd_state, 0);
    chk("rst_spk_vld", spk_valid, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_evt_rdy", evt_ready, 1);
    chk("rst_tick_rdy", tick_ready, 1);

    // integrate, pre counter saturation, then a single spike
    send_evts(3, 7, 25);
    read_chk(3, "acc");
    chk("acc_175", $signed(rd_state), 175);
    chk("acc_pre_sat", rd_pre_cnt, 7);
    tick(0);
    read_chk(3, "fire");

    // subtract mode: one spike per tick, remainder carries
    do_reset();
    param_rst_mode = 1'b1;
    send_evts(4, 7, 35);
    send_evts(4, 5, 1);
    tick(0);
    read_chk(4, "sub1");
    chk("sub1_150", $signed(rd_state), 150);
    tick(0);
    read_chk(4, "sub2");
    chk("sub2_50", $signed(rd_state), 50);
    // cnt_clr wins over a same-cycle increment
    cnt_clr = 1'b1; evt_neur = 4'd4; evt_weight = 4'd1; evt_valid = 1'b1;
    step();
    evt_valid = 1'b0; cnt_clr = 1'b0;
    m_state[4] = sat(m_state[4] + 1);
    for (int i = 0; i < NN; i++) begin m_pre[i] = 0; m_post[i] = 0; end
    read_chk(4, "clr");

    // state saturation at both rails
    do_reset();
    param_rst_mode = 1'b0;
    send_evts(5, 7, 300);
    read_chk(5, "sat_hi");
    chk("sat_hi_2047", $signed(rd_state), 2047);
    send_evts(6, -8, 260);
    read_chk(6, "sat_lo");
    chk("sat_lo_m2048", $signed(rd_state), -2048);

    // first and last neuron fire with a stalled downstream
    do_reset();
    send_evts(0, 7, 15);
    send_evts(15, 7, 15);
    tick(5);
    read_chk(0, "edge0");
    read_chk(15, "edge15");

    // event and tick together: event first, tick next cycle
    do_reset();
    param_thr = 12'd5;
    evt_neur = 4'd2; evt_weight = 4'd7; evt_valid = 1'b1; tick_valid = 1'b1;
    #1;
    chk("both_tick_rdy", tick_ready, 0);
    chk("both_evt_rdy", evt_ready, 1);
    step();
    m_state[2] = sat(m_state[2] + 7);
    m_pre[2]++;
    evt_valid = 1'b0;
    #1;
    chk("tick_rdy_after", tick_ready, 1);
    model_tick();
    step();
    tick_valid = 1'b0;
    wait_sweep(0);
    read_chk(2, "both");

    // reset in the middle of a sweep aborts it
    send_evts(1, 7, 3);
    tick_valid = 1'b1;
    step();
    tick_valid = 1'b0;
    spk_ready = 1'b0;
    repeat (4) step();
    chk("abort_pre_vld", spk_valid, 1);
    chk("abort_pre_neur", spk_neur, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    model_clear();
    chk("abort_spk_vld", spk_valid, 0);
    seen = 0;
    repeat (30) begin
      step();
      if (sweep_done || spk_valid) seen++;
    end
    chk("abort_no_done", seen, 0);
    read_chk(1, "abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_neuron_array.md
Name: if_neuron_array

Overview:
- Time-multiplexed integrate-and-fire engine holding membrane state plus pre/post spike counters for NUM_NEURONS neurons in registers.
- Synaptic events integrate weights into a target neuron, one event per handshake.
- A time-reference tick starts a sweep over all neurons that fires, resets and streams out spikes.
- Sits between the synapse/event router and the spike output FIFO of the core; generalised, sequential successor of the single combinational IF neuron.

Parameters:
- NUM_NEURONS, 16, neurons held; at least 2.
- STATE_W, 12, membrane state width, two's complement.
- WEIGHT_W, 4, synaptic weight width, two's complement.
- CNT_W, 3, pre/post spike counter width, saturating.
- N_W, $clog2(NUM_NEURONS), neuron index width (derived).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active high.
- param_thr  in  STATE_W  firing threshold, unsigned positive, must be below 2^(STATE_W-1).
- param_rst_mode  in  1  0 = reset to zero on spike, 1 = subtract threshold.
- evt_valid  in  1  synaptic event valid.
- evt_ready  out  1  event accepted when valid&ready.
- evt_neur  in  N_W  target neuron.
- evt_weight  in  WEIGHT_W  signed weight.
- tick_valid  in  1  time-reference request.
- tick_ready  out  1  tick accepted when valid&ready.
- spk_valid  out  1  spike output valid.
- spk_ready  in  1  downstream accepts spike.
- spk_neur  out  N_W  index of the spiking neuron.
- sweep_done  out  1  one-cycle pulse after the last neuron is processed.
- rd_neur  in  N_W  debug read address.
- rd_state  out  STATE_W  registered state of rd_neur.
- rd_pre_cnt  out  CNT_W  registered pre counter.
- rd_post_cnt  out  CNT_W  registered post counter.
- cnt_clr  in  1  clears all pre/post counters.

Behaviour:
- Reset (RST high at a CLK edge):
  - All states, counters and rd_* go to 0.
  - FSM goes to IDLE.
  - spk_valid=0, sweep_done=0, spk_neur=0.
  - RST mid-sweep aborts the sweep; no sweep_done is issued.
- FSM states: IDLE, SWEEP, EMIT.
- IDLE:
  - evt_ready=1.
  - tick_ready=1 only when evt_valid=0, so an event wins over a simultaneous tick.
  - Accepted event:
    - state[evt_neur] <= sat(state + sign_ext(evt_weight)), clamped to [-2^(STATE_W-1), 2^(STATE_W-1)-1].
    - pre_cnt[evt_neur] increments, saturating at 2^CNT_W-1.
    - Update visible on the next cycle; back-to-back events to the same neuron accumulate correctly at full rate.
  - Accepted tick: index <= 0, go to SWEEP.
- SWEEP, one neuron per cycle:
  - evt_ready=0, tick_ready=0.
  - If signed state[index] >= param_thr:
    - Spike.
    - state <= 0 (mode 0) or state - param_thr (mode 1).
    - post_cnt increments, saturating.
    - spk_valid <= 1, spk_neur <= index, go to EMIT.
  - Otherwise advance index.
  - After index NUM_NEURONS-1 (no spike): sweep_done pulses next cycle, return to IDLE.
- EMIT:
  - Hold spk_valid and spk_neur stable until spk_ready.
  - On handshake, drop spk_valid next cycle.
  - Then advance index, or finish exactly as SWEEP does if this was the last neuron.
- Sweep latency: NUM_NEURONS cycles plus one cycle per spike plus spk_ready stall cycles.
- Mode 1: a state of 2*thr emits only one spike per tick; the remainder carries to the next tick.
- cnt_clr has priority over increments in the same cycle, in any state.
- Parameter inputs are sampled per use and must be held stable during a sweep.
- rd_* outputs have one-cycle read latency and reflect post-update values.

Optional Feature:
- Macro: IF_NEURON_LEAK_EN.
- When defined:
  - Adds input param_leak [STATE_W-2:0].
  - During a sweep, each non-spiking neuron leaks toward zero by param_leak.
  - Positive states clamp at 0 from above; negative states clamp at 0 from below.
  - Leak is applied in the same cycle as that neuron's threshold check.
- When undefined: no port, and state is untouched for non-spiking neurons.

Decomposition:
- Package if_neuron_pkg:
  - FSM state enumeration (IDLE/SWEEP/EMIT).
  - Reset-mode constants RST_ZERO/RST_SUB.
  - Default widths.
  - Saturating-add function.
- Sub-module if_neuron_core:
  - Combinational per-neuron update (integrate, threshold compare, reset, optional leak).
  - Instantiated once and shared by the event and sweep paths through an operand mux.

Test Plan:
- Reset, thr=100, mode 0, 25 events of weight +7 to neuron 3 → rd_state=175, rd_pre_cnt=7 (saturated).
- Same setup, then tick with spk_ready=1 → spk_valid once with spk_neur=3; neuron 3 state=0, post_cnt=1; sweep_done after 17 cycles.
- Mode 1, state 250, thr=100 → tick 1 leaves 150, tick 2 leaves 50; one spike per tick.
- Events of weight +7 until state is 2047 → stays 2047; weight -8 from -2048 stays -2048.
- Neurons 0 and 15 over threshold, spk_ready held low 5 cycles → spk_neur=0 stable for 5 cycles, then 15; evt_ready=0 throughout the sweep.
- evt_valid and tick_valid high together in IDLE → event is applied first, tick accepted next cycle; RST asserted mid-sweep → spk_valid=0 and no sweep_done.
